rom_fetch_resp: RTL and testbench
=================================

# rom_fetch_resp

Instruction-fetch responder on the ROM side of the CPU's `rom_ce`/`rom_addr`/`rom_data` port. It answers 32-bit word fetches by reading four bytes from a byte-wide synchronous instruction memory and assembling them little-endian. A one-entry last-word buffer lets repeated fetches of the same word return in one cycle. It sits between the CPU top and the external byte memory, and adds `rom_valid_o`/`busy_o` so the fetch stage can stall.

## Interface
- `ADDR_W`, default 17: byte-address width of the external memory.
- `clk_in` in 1: system clock. All state changes on its rising edge.
- `rst_in` in 1: asynchronous, active-high reset.
- `rom_ce_i` in 1: fetch request from the CPU.
- `rom_addr_i` in 32: fetch byte address from the CPU.
- `rom_data_o` out 32: fetched instruction word.
- `rom_valid_o` out 1: one-cycle pulse; `rom_data_o` is valid in that cycle.
- `busy_o` out 1: high whenever the state is not IDLE.
- `flush_i` in 1: invalidates the last-word buffer.
- `mem_addr_o` out ADDR_W: byte address to the external memory.
- `mem_din_i` in 8: memory read data for the address presented in the previous cycle (fixed 1-cycle latency).

## Operation
- Word address is `rom_addr_i[ADDR_W-1:2]`. Bits [1:0] and bits above ADDR_W-1 are ignored. Accesses are always aligned, so the byte address never wraps.
- Last-word buffer holds `{valid, tag[ADDR_W-3:0], data[31:0]}`.
- **State machine:** IDLE, ISSUE, WAIT, RESP.
- **IDLE.** Requests are sampled only here.
  - `rom_ce_i=0`: stay in IDLE.
  - Hit (buffer valid, tag matches): go to RESP; the response data is the buffer data.
  - Miss: latch the base word address, clear the byte counter `cnt`, go to ISSUE.
- **ISSUE.** `mem_addr_o = {base, cnt[1:0]}`. `cnt` counts 0..3, then the state goes to WAIT.
- **Byte capture.** Each cycle after an ISSUE cycle, `mem_din_i` is written into byte lane `cnt_d` of the assembly register, where `cnt_d` is `cnt` delayed one cycle. Lane 0 is bits [7:0].
- **WAIT.** Captures the last byte, then goes to RESP.
- **RESP.** `rom_valid_o=1` and `rom_data_o` = assembled word (miss) or buffered word (hit).
  - On a miss, the buffer is written with `valid=1`, `tag=base`, `data=word`.
  - Next state is IDLE.
- `mem_addr_o` is 0 outside ISSUE.
- `rom_data_o` holds its last value between pulses.
- Inputs `rom_ce_i`/`rom_addr_i` are ignored while `busy_o=1`.
  - If the address changes mid-fetch, the original fetch completes and is buffered.
  - The CPU re-requests; a differing address misses.
- **`flush_i`:**
  - In any state, clears `buffer.valid` on the next edge.
  - In the same cycle as a RESP miss write, flush wins: the word is still delivered, but the buffer stays invalid.
  - An IDLE hit check in the same cycle as `flush_i` treats the buffer as invalid, so the request misses.
- **Reset:**
  - Values: state IDLE; `rom_valid_o=0`; `rom_data_o=0`; `busy_o=0`; `mem_addr_o=0`; buffer invalid; `cnt=0`.
  - Reset mid-fetch aborts the fetch with no valid pulse.

## Timing
- Request sampled in IDLE at cycle T.
- **Hit:** `rom_valid_o` at T+1, latency 1. Back-to-back hits: the next request is sampled at T+2, giving one word per 2 cycles.
- **Miss:**
  - `mem_addr_o` = base+0..3 at T+1..T+4.
  - Bytes captured at the edges ending T+2..T+5.
  - `rom_valid_o` at T+6, latency 6.
  - IDLE again at T+7.
- `busy_o` is high for T+1..T+6 on a miss, and T+1 on a hit.
- `rom_valid_o` is never high for two consecutive cycles.

## Structure
- **Shared package `rom_fetch_pkg`:**
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - `BYTES_PER_WORD = 4`;
  - `CNT_W = 2`;
  - `ADDR_W` default constant.
- **Sub-module `fetch_word_buf`:**
  - tag/data/valid register with write port, flush, and combinational hit compare;
  - same `clk_in`/`rst_in`.
- FSM, counter and byte assembly stay in `rom_fetch_resp`.

## Test plan
All scenarios use a memory model with `mem[i] = i & 0xFF` and 1-cycle read latency.
- Reset, then fetch 0x10 → `mem_addr_o` 0x10,0x11,0x12,0x13 at T+1..T+4; `rom_data_o=0x13121110`, `rom_valid_o` pulse at T+6 only.
- Refetch 0x10 immediately after → valid at T+1, data 0x13121110, `mem_addr_o` stays 0.
- Fetch 0x0002_0012 with ADDR_W=17 after buffering 0x10 → hit at T+1 (upper and low bits ignored), data 0x13121110.
- `flush_i` pulse, then fetch 0x10 → miss, latency 6. Separately, flush coincident with RESP → data delivered, next fetch of the same address misses.
- Change `rom_addr_i` to 0x20 at T+3 of a miss on 0x10 → 0x13121110 delivered at T+6; the next sample of 0x20 misses and returns 0x23222120.
- Assert `rst_in` asynchronously at T+3 of a miss → outputs 0 immediately, no `rom_valid_o` pulse, buffer invalid (refetch of 0x10 misses).

Source files
------------

// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM-side instruction fetch responder.
package rom_fetch_pkg;

  localparam int ADDR_W_DEFAULT = 17;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 2;
  localparam int WORD_W         = BYTES_PER_WORD * 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_word_buf.sv
// One-entry last-word buffer: tag/data/valid with write port, flush and
// combinational hit compare. A flush in the current cycle masks the hit.
module fetch_word_buf
  import rom_fetch_pkg::*;
#(
  parameter int TAG_W = ADDR_W_DEFAULT - 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              flush,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [WORD_W-1:0] rd_data
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [WORD_W-1:0] data_q;

  // Valid bit: flush has priority over a same-cycle write
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
    end
  end

  // Tag and data payload, qualified by valid_q so no reset needed
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q  <= wr_tag;
      data_q <= wr_data;
    end
  end

  assign hit     = valid_q && !flush && (tag_q == lookup_tag);
  assign rd_data = data_q;

endmodule

// File: rtl/rom_fetch_resp.sv
// Instruction-fetch responder: assembles 32-bit little-endian words from a
// byte-wide memory with 1-cycle read latency, with a one-entry word buffer.
module rom_fetch_resp
  import rom_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              rom_valid_o,
  output logic              busy_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_din_i
);

  localparam int TAG_W = ADDR_W - 2;

  state_t              state_q, state_nx;
  logic [TAG_W-1:0]    base_q;
  logic [TAG_W-1:0]    req_tag;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_p1;
  logic                vld_p1;
  logic                hit_q;
  logic [WORD_W-1:0]   asm_q, asm_nx;
  logic                buf_hit;
  logic [WORD_W-1:0]   buf_data;
  logic                buf_wr;
  logic                unused_addr_bits;

  // Replace one byte lane of a word; lane 0 is bits [7:0]
  function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] word,
                                                 input logic [CNT_W-1:0]  lane,
                                                 input logic [7:0]        b);
    logic [WORD_W-1:0] w;
    w = word;
    w[{lane, 3'b000} +: 8] = b;
    return w;
  endfunction

  assign req_tag          = rom_addr_i[ADDR_W-1:2];
  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W], rom_addr_i[1:0]};
  assign buf_wr           = (state_q == RESP) && !hit_q;

  fetch_word_buf #(
    .TAG_W(TAG_W)
  ) u_buf (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .wr_en     (buf_wr),
    .wr_tag    (base_q),
    .wr_data   (rom_data_o),
    .flush     (flush_i),
    .lookup_tag(req_tag),
    .hit       (buf_hit),
    .rd_data   (buf_data)
  );

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state and combinational outputs
  always_comb begin
    state_nx    = state_q;
    rom_valid_o = 1'b0;
    busy_o      = 1'b1;
    mem_addr_o  = '0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (rom_ce_i) begin
          state_nx = buf_hit ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        mem_addr_o = {base_q, cnt_q};
        if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        state_nx = RESP;
      end
      RESP: begin
        rom_valid_o = 1'b1;
        state_nx    = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Request latch, byte counter and hit flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      base_q <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && rom_ce_i) begin
        hit_q <= buf_hit;
        if (!buf_hit) begin
          base_q <= req_tag;
          cnt_q  <= '0;
        end
      end else if (state_q == ISSUE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // ---- stage p1: memory data returns one cycle after its address ----
  // Capture strobe and lane index delayed to line up with mem_din_i
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      vld_p1 <= (state_q == ISSUE);
      cnt_p1 <= cnt_q;
    end
  end

  // Byte lane merge for the assembly register
  always_comb begin
    asm_nx = asm_q;
    if (vld_p1) begin
      asm_nx = put_lane(asm_q, cnt_p1, mem_din_i);
    end
  end

  // Assembly register holds partial words only; no reset needed
  always_ff @(posedge clk_in) begin
    asm_q <= asm_nx;
  end

  // Response word: loaded on entry to RESP, held between pulses
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rom_data_o <= '0;
    end else if (state_q == IDLE && rom_ce_i && buf_hit) begin
      rom_data_o <= buf_data;
    end else if (state_q == WAIT) begin
      rom_data_o <= asm_nx;
    end
  end

endmodule

// File: tb/tb_rom_fetch_resp.sv
// Directed bench for rom_fetch_resp with a byte memory model mem[i] = i & 0xFF.
module tb_rom_fetch_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr_i;
  logic [31:0] data_o;
  logic        valid;
  logic        busy;
  logic        flush;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int consec = 0;
  logic prev_v = 1'b0;

  typedef struct {
    logic [31:0] addr;
    bit          flush_pre;
    bit          flush_resp;
    int          lat;
    logic [31:0] data;
  } vec_t;

  vec_t vec [13];

  rom_fetch_resp #(.ADDR_W(17)) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .rom_ce_i   (ce),
    .rom_addr_i (addr_i),
    .rom_data_o (data_o),
    .rom_valid_o(valid),
    .busy_o     (busy),
    .flush_i    (flush),
    .mem_addr_o (mem_addr),
    .mem_din_i  (mem_din)
  );

  always #5 clk = ~clk;

  // byte memory, 1-cycle read latency
  always @(posedge clk) mem_din <= mem_addr[7:0];

  // valid pulse monitor
  always @(posedge clk) begin
    if (valid) vcnt++;
    if (valid && prev_v) consec++;
    prev_v = valid;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Issue one fetch from IDLE and check latency, data, memory addresses, busy.
  task automatic do_fetch(input string nm, input logic [31:0] a, input bit flush_resp,
                          input int exp_lat, input logic [31:0] exp_data);
    int lat;
    int bcnt;
    bit got;
    bit ma_ok;
    logic [31:0] exp_ma;
    ce = 1'b1;
    addr_i = a;
    lat = 0;
    bcnt = 0;
    got = 1'b0;
    ma_ok = 1'b1;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      ce = 1'b0;
      lat++;
      if (busy) bcnt++;
      exp_ma = 32'h0;
      if (exp_lat == 6 && lat >= 1 && lat <= 4) exp_ma = (a & 32'h1FFFC) + 32'(lat - 1);
      if ({15'h0, mem_addr} !== exp_ma) ma_ok = 1'b0;
      if (valid) got = 1'b1;
    end
    check({nm, "_lat"}, got ? lat : 99, exp_lat);
    check({nm, "_data"}, data_o, exp_data);
    check({nm, "_memaddr"}, {31'h0, ma_ok}, 32'h1);
    check({nm, "_busycnt"}, bcnt, exp_lat);
    if (flush_resp) flush = 1'b1;
    step();
    flush = 1'b0;
    check({nm, "_idle"}, {30'h0, busy, valid}, 32'h0);
  endtask

  initial begin
    int lat;
    int v0;
    bit got;

    vec[0]  = '{32'h0000_0010, 1'b0, 1'b0, 6, 32'h1312_1110};
    vec[1]  = '{32'h0000_0010, 1'b0, 1'b0, 1, 32'h1312_1110};
    vec[2]  = '{32'h0002_0012, 1'b0, 1'b0, 1, 32'h1312_1110};
    vec[3]  = '{32'h0000_0010, 1'b1, 1'b0, 6, 32'h1312_1110};
    vec[4]  = '{32'h0000_0010, 1'b0, 1'b0, 1, 32'h1312_1110};
    vec[5]  = '{32'h0000_0040, 1'b0, 1'b0, 6, 32'h4342_4140};
    vec[6]  = '{32'h0000_0010, 1'b0, 1'b0, 6, 32'h1312_1110};
    vec[7]  = '{32'h0001_FFFC, 1'b0, 1'b0, 6, 32'hFFFE_FDFC};
    vec[8]  = '{32'h0001_FFFF, 1'b0, 1'b0, 1, 32'hFFFE_FDFC};
    vec[9]  = '{32'h0003_FFFC, 1'b0, 1'b0, 1, 32'hFFFE_FDFC};
    vec[10] = '{32'h0000_0080, 1'b0, 1'b1, 6, 32'h8382_8180};
    vec[11] = '{32'h0000_0080, 1'b0, 1'b0, 6, 32'h8382_8180};
    vec[12] = '{32'h0000_0080, 1'b0, 1'b0, 1, 32'h8382_8180};

    rst = 1'b1;
    ce = 1'b0;
    addr_i = 32'h0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_data", data_o, 32'h0);
    check("rst_memaddr", {15'h0, mem_addr}, 32'h0);
    rst = 1'b0;
    step();

    // table-driven fetches
    for (int i = 0; i < 13; i++) begin
      if (vec[i].flush_pre) pulse_flush();
      do_fetch($sformatf("v%0d", i), vec[i].addr, vec[i].flush_resp, vec[i].lat, vec[i].data);
    end

    // address change mid-fetch: original completes, new address misses later
    pulse_flush();
    ce = 1'b1;
    addr_i = 32'h10;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      lat++;
      if (lat == 3) addr_i = 32'h20;
      if (valid) got = 1'b1;
    end
    check("chg_lat", got ? lat : 99, 6);
    check("chg_data", data_o, 32'h1312_1110);
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 14 && !got; k++) begin
      step();
      lat++;
      if (valid) got = 1'b1;
    end
    ce = 1'b0;
    check("chg2_lat", got ? lat : 99, 7);
    check("chg2_data", data_o, 32'h2322_2120);
    step();
    do_fetch("chg3", 32'h20, 1'b0, 1, 32'h2322_2120);

    // asynchronous reset mid-fetch
    do_fetch("pre_rst", 32'h40, 1'b0, 6, 32'h4342_4140);
    do_fetch("pre_rst_hit", 32'h40, 1'b0, 1, 32'h4342_4140);
    v0 = vcnt;
    ce = 1'b1;
    addr_i = 32'h10;
    step();
    ce = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'h0, valid}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_data", data_o, 32'h0);
    check("arst_memaddr", {15'h0, mem_addr}, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    step();
    step();
    step();
    check("arst_nopulse", vcnt - v0, 0);
    do_fetch("post_rst", 32'h40, 1'b0, 6, 32'h4342_4140);
    do_fetch("post_rst2", 32'h10, 1'b0, 6, 32'h1312_1110);

    check("valid_consec", consec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
